// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: reset address,
// FSM encoding and instruction-word constants.
package fetch_unit_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // Canonical NOP (addi x0, x0, 0) for decode bubble insertion.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} pairs for decode.
// The controller guarantees push only when not full and pop only when
// not empty; flush wins over push/pop and empties the queue in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    // NOTE: the data array has no reset; an empty FIFO is defined by count,
    // and the head is masked downstream whenever nothing is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, the RUN/HALT FSM, the
// misaligned-redirect fault register and the FIFO push/pop/flush control.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_instr,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_dec_valid,
    output logic [31:0] o_dec_instr,
    output logic [31:0] o_dec_pc,
    input  logic        i_dec_ready,
    output logic        o_fault,
    output logic [31:0] o_fault_pc
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    state_t                    state;
    state_t                    state_next;
    logic [31:0]               fetch_pc;
    logic [CW-1:0]             count;
    logic [2*INSTR_W-1:0]      head;
    logic                      push;
    logic                      pop;
    logic                      misaligned;
    logic                      dec_valid;

    assign misaligned = (i_redirect_pc[1:0] != 2'b00);

    // Next-state and push decision; a redirect overrides everything.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        if (i_redirect_valid) begin
            state_next = misaligned ? HALT : RUN;
        end else if (state == RUN) begin
            push = (count < DEPTH_C);
        end
    end

    // Head is hidden from decode during the redirect cycle itself.
    assign dec_valid   = (count != '0) && !i_redirect_valid;
    assign pop         = dec_valid && i_dec_ready;
    assign o_dec_valid = dec_valid;
    assign o_dec_pc    = dec_valid ? head[2*INSTR_W-1:INSTR_W] : 32'h0;
    assign o_dec_instr = dec_valid ? head[INSTR_W-1:0]         : 32'h0;
    assign o_imem_addr = fetch_pc;

    // FSM state register.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the values present before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    // Fetch PC: redirect loads the word-aligned target, a push advances by one word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  fetch_pc <= RESET_PC;
        else if (i_redirect_valid) fetch_pc <= {i_redirect_pc[31:2], 2'b00};
        else if (push)             fetch_pc <= fetch_pc + 32'd4;
    end

    // Fault pulse and sticky offending address for misaligned redirects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_fault    <= 1'b0;
            o_fault_pc <= 32'h0;
        end else begin
            o_fault <= i_redirect_valid && misaligned;
            if (i_redirect_valid && misaligned) o_fault_pc <= i_redirect_pc;
        end
    end

    fetch_fifo #(
        .WIDTH (2*INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (i_redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({fetch_pc, i_imem_instr}),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by
// random redirect/stall traffic, compared against a queue-based model.
// A second instance with RESET_PC = FFFF_FFF8 streams freely to show PC wrap.
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        fault;
    logic [31:0] fault_pc;

    logic [31:0] imem_addr2;
    logic [31:0] imem_instr2;
    logic        dec_valid2;
    logic [31:0] dec_instr2;
    logic [31:0] dec_pc2;
    logic        fault2;
    logic [31:0] fault_pc2;
    logic        redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2    = 32'h0;
    logic        dec_ready2      = 1'b1;

    always #5 clk = ~clk;

    // Memory word k holds value k.
    assign imem_instr  = imem_addr  >> 2;
    assign imem_instr2 = imem_addr2 >> 2;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .o_imem_addr      (imem_addr),
        .i_imem_instr     (imem_instr),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_dec_valid      (dec_valid),
        .o_dec_instr      (dec_instr),
        .o_dec_pc         (dec_pc),
        .i_dec_ready      (dec_ready),
        .o_fault          (fault),
        .o_fault_pc       (fault_pc)
    );

    fetch_unit #(.RESET_PC(RPC2), .DEPTH(DEPTH)) dut2 (
        .clk              (clk),
        .rst              (rst),
        .o_imem_addr      (imem_addr2),
        .i_imem_instr     (imem_instr2),
        .i_redirect_valid (redirect_valid2),
        .i_redirect_pc    (redirect_pc2),
        .o_dec_valid      (dec_valid2),
        .o_dec_instr      (dec_instr2),
        .o_dec_pc         (dec_pc2),
        .i_dec_ready      (dec_ready2),
        .o_fault          (fault2),
        .o_fault_pc       (fault_pc2)
    );

    int passed = 0;
    int total  = 0;

    // Reference model state.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_fault;
    logic [31:0] m_fault_pc;
    int unsigned m_n2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc       = 32'h0;
        m_halted   = 1'b0;
        m_fault    = 1'b0;
        m_fault_pc = 32'h0;
        m_n2       = 0;
    endtask

    task automatic check_outputs();
        logic        v;
        logic [31:0] a2;
        v = (m_q.size() != 0) && !redirect_valid;
        check("imem_addr", imem_addr, m_pc);
        check("dec_valid", {31'h0, dec_valid}, {31'h0, v});
        check("dec_pc",    dec_pc,    v ? m_q[0][63:32] : 32'h0);
        check("dec_instr", dec_instr, v ? m_q[0][31:0]  : 32'h0);
        check("fault",     {31'h0, fault}, {31'h0, m_fault});
        check("fault_pc",  fault_pc, m_fault_pc);
        // Free-running second instance: word n after reset is RPC2 + 4n.
        a2 = RPC2 + 32'(4 * m_n2);
        check("wrap_addr",  imem_addr2, a2);
        check("wrap_valid", {31'h0, dec_valid2}, {31'h0, (m_n2 != 0)});
        check("wrap_pc",    dec_pc2, (m_n2 != 0) ? a2 - 32'd4 : 32'h0);
    endtask

    // Apply the spec rules for one clock edge.
    task automatic model_update();
        logic pop_now;
        logic push_now;
        if (redirect_valid) begin
            m_q.delete();
            m_fault = (redirect_pc[1:0] != 2'b00);
            if (m_fault) m_fault_pc = redirect_pc;
            m_halted = m_fault;
            m_pc     = {redirect_pc[31:2], 2'b00};
        end else begin
            m_fault  = 1'b0;
            pop_now  = (m_q.size() != 0) && dec_ready;
            push_now = !m_halted && (m_q.size() < DEPTH);
            if (pop_now) void'(m_q.pop_front());
            if (push_now) begin
                m_q.push_back({m_pc, m_pc >> 2});
                m_pc = m_pc + 32'd4;
            end
        end
        m_n2++;
    endtask

    task automatic step(input logic v, input logic [31:0] rpc, input logic rdy);
        redirect_valid = v;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        logic [31:0] base;
        logic [31:0] tgt;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b1;

        // Streaming with decode always ready.
        repeat (8) step(1'b0, 32'h0, 1'b1);
        // Decode stall, then recovery.
        repeat (5) step(1'b0, 32'h0, 1'b0);
        repeat (6) step(1'b0, 32'h0, 1'b1);
        // Fill, then redirect while full.
        repeat (3) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b1);
        repeat (4) step(1'b0, 32'h0, 1'b1);
        // Misaligned redirect halts fetch; aligned redirect resumes.
        step(1'b1, 32'h0000_0102, 1'b1);
        repeat (4) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1);
        repeat (4) step(1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0:       base = 32'h0000_0000;
                1:       base = 32'h0000_1000;
                default: base = 32'hFFFF_FFE0;
            endcase
            tgt = base + {26'h0, 4'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 4) == 0) tgt = tgt + 32'($urandom_range(1, 3));
            step(($urandom_range(0, 9) == 0), tgt, ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset mid-stream with a full FIFO and a sticky fault address.
        step(1'b1, 32'h0000_0333, 1'b1);
        step(1'b1, 32'h0000_0040, 1'b0);
        repeat (4) step(1'b0, 32'h0, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) step(1'b0, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
